// File: rtl/c8237_pkg.sv
// Shared types and constants for the 8237-style DMA priority/arbitration slice.
package c8237_pkg;

  localparam int unsigned CH_N = 4;
  localparam int unsigned CH_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // DACK pin word: one-hot on chan when en, mapped to the selected pin polarity.
  function automatic logic [CH_N-1:0] dack_word(input logic [CH_W-1:0] chan,
                                                input logic en,
                                                input logic act_hi);
    logic [CH_N-1:0] oh;
    oh = en ? (CH_N'(1) << chan) : '0;
    return act_hi ? oh : ~oh;
  endfunction

endpackage

// File: rtl/c8237_prio_enc.sv
// Combinational rotating-priority encoder: first requesting channel at or after pointer.
module c8237_prio_enc
  import c8237_pkg::*;
(
  input  logic [CH_N-1:0] eff,
  input  logic [CH_W-1:0] pointer,
  output logic            valid,
  output logic [CH_W-1:0] chan
);

  logic [CH_W-1:0] w_idx;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    valid = 1'b0;
    chan  = '0;
    w_idx = '0;
    for (int i = int'(CH_N) - 1; i >= 0; i--) begin
      w_idx = pointer + CH_W'(i);
      if (eff[w_idx]) begin
        valid = 1'b1;
        chan  = w_idx;
      end
    end
  end

endmodule

// File: rtl/c8237_priority.sv
// DMA request arbitration: request qualification, CPU hold handshake, channel grant and priority rotation.
module c8237_priority
  import c8237_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic [CH_N-1:0] DREQ,
  input  logic            HLDA,
  input  logic            cmd_disable,
  input  logic            cmd_rotate,
  input  logic            cmd_dreq_lo,
  input  logic            cmd_dack_hi,
  input  logic [CH_N-1:0] mask,
  input  logic [CH_N-1:0] soft_req,
  input  logic            svc_done,
  output logic            HRQ,
  output logic [CH_N-1:0] DACK,
  output logic [CH_W-1:0] svc_chan,
  output logic            svc_start,
  output logic            svc_abort,
  output logic            busy
);

  state_e          r_state;
  logic            r_hrq;
  logic [CH_N-1:0] r_dack;
  logic [CH_W-1:0] r_chan;
  logic            r_start;
  logic            r_abort;
  logic            r_busy;
  logic [CH_W-1:0] r_ptr;

  logic [CH_N-1:0] w_eff;
  logic [CH_W-1:0] w_ptr;
  logic            w_valid;
  logic [CH_W-1:0] w_win;

  // Qualified requests: pin polarity, hardware mask, then unmaskable software requests.
  assign w_eff = ((DREQ ^ {CH_N{cmd_dreq_lo}}) & ~mask) | soft_req;

  // Fixed priority is the rotating search anchored at channel 0.
  assign w_ptr = cmd_rotate ? r_ptr : '0;

  c8237_prio_enc u_enc (
    .eff     (w_eff),
    .pointer (w_ptr),
    .valid   (w_valid),
    .chan    (w_win)
  );

  // Arbitration FSM with registered handshake outputs; DACK re-mapped to current polarity each cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_hrq   <= 1'b0;
      r_dack  <= {CH_N{~cmd_dack_hi}};
      r_chan  <= '0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_dack  <= dack_word(r_chan, 1'b0, cmd_dack_hi);
      case (r_state)
        ST_IDLE: begin
          if (w_valid && !cmd_disable) begin
            r_state <= ST_HOLD;
            r_hrq   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (!w_valid) begin
            r_state <= ST_IDLE;
            r_hrq   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (HLDA) begin
            r_state <= ST_GRANT;
            r_chan  <= w_win;
            r_start <= 1'b1;
            r_dack  <= dack_word(w_win, 1'b1, cmd_dack_hi);
          end
        end
        ST_GRANT: begin
          if (svc_done) begin
            // Completion wins over a simultaneous HLDA drop.
            r_state <= ST_RELEASE;
            r_hrq   <= 1'b0;
            if (cmd_rotate) r_ptr <= r_chan + CH_W'(1);
          end else if (!HLDA) begin
            r_state <= ST_IDLE;
            r_hrq   <= 1'b0;
            r_abort <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_dack  <= dack_word(r_chan, 1'b1, cmd_dack_hi);
          end
        end
        ST_RELEASE: begin
          if (!HLDA) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_hrq   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign HRQ       = r_hrq;
  assign DACK      = r_dack;
  assign svc_chan  = r_chan;
  assign svc_start = r_start;
  assign svc_abort = r_abort;
  assign busy      = r_busy;

endmodule

// File: tb/tb_c8237_priority.sv
// Directed self-checking bench for c8237_priority.
module tb_c8237_priority;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic       HLDA;
  logic       cmd_disable;
  logic       cmd_rotate;
  logic       cmd_dreq_lo;
  logic       cmd_dack_hi;
  logic [3:0] mask;
  logic [3:0] soft_req;
  logic       svc_done;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] svc_chan;
  logic       svc_start;
  logic       svc_abort;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  c8237_priority dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .DREQ        (DREQ),
    .HLDA        (HLDA),
    .cmd_disable (cmd_disable),
    .cmd_rotate  (cmd_rotate),
    .cmd_dreq_lo (cmd_dreq_lo),
    .cmd_dack_hi (cmd_dack_hi),
    .mask        (mask),
    .soft_req    (soft_req),
    .svc_done    (svc_done),
    .HRQ         (HRQ),
    .DACK        (DACK),
    .svc_chan    (svc_chan),
    .svc_start   (svc_start),
    .svc_abort   (svc_abort),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One full service from IDLE with requests pending (DACK active-low).
  task automatic do_service(input string tag, input logic [1:0] exp_chan);
    logic [3:0] exp_dack;
    exp_dack = 4'b1111;
    exp_dack[exp_chan] = 1'b0;
    tick();
    chk({tag, "_hrq"}, {3'b0, HRQ}, 4'd1);
    HLDA = 1'b1;
    tick();
    chk({tag, "_chan"}, {2'b0, svc_chan}, {2'b0, exp_chan});
    chk({tag, "_start"}, {3'b0, svc_start}, 4'd1);
    chk({tag, "_dack"}, DACK, exp_dack);
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    chk({tag, "_rel_hrq"}, {3'b0, HRQ}, 4'd0);
    chk({tag, "_rel_dack"}, DACK, 4'b1111);
    HLDA = 1'b0;
    tick();
    chk({tag, "_idle"}, {3'b0, busy}, 4'd0);
  endtask

  initial begin
    RESET = 1'b1; DREQ = 4'b0; HLDA = 1'b0; cmd_disable = 1'b0; cmd_rotate = 1'b0;
    cmd_dreq_lo = 1'b0; cmd_dack_hi = 1'b0; mask = 4'b0; soft_req = 4'b0; svc_done = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    chk("rst_hrq", {3'b0, HRQ}, 4'd0);
    chk("rst_dack", DACK, 4'b1111);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_chan", {2'b0, svc_chan}, 4'd0);
    chk("rst_start", {3'b0, svc_start}, 4'd0);
    chk("rst_abort", {3'b0, svc_abort}, 4'd0);

    // Fixed priority, HLDA two cycles after HRQ.
    DREQ = 4'b0110;
    tick();
    chk("fix_hrq", {3'b0, HRQ}, 4'd1);
    chk("fix_busy", {3'b0, busy}, 4'd1);
    tick();
    chk("fix_hold_dack", DACK, 4'b1111);
    HLDA = 1'b1;
    tick();
    chk("fix_dack", DACK, 4'b1101);
    chk("fix_chan", {2'b0, svc_chan}, 4'd1);
    chk("fix_start", {3'b0, svc_start}, 4'd1);
    DREQ = 4'b0001;
    tick();
    chk("fix_start_once", {3'b0, svc_start}, 4'd0);
    chk("fix_chan_stable", {2'b0, svc_chan}, 4'd1);
    chk("fix_dack_hold", DACK, 4'b1101);
    svc_done = 1'b1;
    DREQ = 4'b0000;
    tick();
    svc_done = 1'b0;
    chk("fix_rel_hrq", {3'b0, HRQ}, 4'd0);
    chk("fix_rel_dack", DACK, 4'b1111);
    chk("fix_rel_busy", {3'b0, busy}, 4'd1);
    tick();
    chk("fix_rel_min", {3'b0, HRQ}, 4'd0);
    HLDA = 1'b0;
    tick();
    chk("fix_idle", {3'b0, busy}, 4'd0);
    chk("fix_ptr", {2'b0, dut.r_ptr}, 4'd0);

    // Rotating priority, all channels requesting.
    cmd_rotate = 1'b1;
    DREQ = 4'b1111;
    do_service("rot0", 2'd0);
    do_service("rot1", 2'd1);
    do_service("rot2", 2'd2);
    do_service("rot3", 2'd3);
    do_service("rot4", 2'd0);
    DREQ = 4'b0000;
    chk("rot_ptr", {2'b0, dut.r_ptr}, 4'd1);

    // Request withdrawn while in HOLD.
    tick();
    DREQ = 4'b0001;
    tick();
    chk("wd_hrq", {3'b0, HRQ}, 4'd1);
    DREQ = 4'b0000;
    tick();
    chk("wd_hrq_fall", {3'b0, HRQ}, 4'd0);
    chk("wd_busy", {3'b0, busy}, 4'd0);
    chk("wd_dack", DACK, 4'b1111);
    chk("wd_start", {3'b0, svc_start}, 4'd0);

    // HLDA lost during GRANT; pointer 1 picks channel 2.
    DREQ = 4'b0100;
    tick();
    HLDA = 1'b1;
    tick();
    chk("ab_chan", {2'b0, svc_chan}, 4'd2);
    chk("ab_dack_g", DACK, 4'b1011);
    HLDA = 1'b0;
    DREQ = 4'b0000;
    tick();
    chk("ab_abort", {3'b0, svc_abort}, 4'd1);
    chk("ab_dack", DACK, 4'b1111);
    chk("ab_hrq", {3'b0, HRQ}, 4'd0);
    chk("ab_busy", {3'b0, busy}, 4'd0);
    chk("ab_ptr", {2'b0, dut.r_ptr}, 4'd1);
    tick();
    chk("ab_abort_pulse", {3'b0, svc_abort}, 4'd0);

    // Masking, soft request, active-low DREQ pins under fixed priority.
    cmd_rotate = 1'b0;
    cmd_dreq_lo = 1'b1;
    DREQ = 4'b1110;
    mask = 4'b0001;
    soft_req = 4'b0100;
    do_service("msk", 2'd2);
    soft_req = 4'b0000;
    mask = 4'b0000;
    cmd_dreq_lo = 1'b0;
    DREQ = 4'b0000;
    chk("msk_ptr", {2'b0, dut.r_ptr}, 4'd1);

    // svc_done with simultaneous HLDA drop completes normally.
    cmd_rotate = 1'b1;
    DREQ = 4'b0010;
    tick();
    HLDA = 1'b1;
    tick();
    chk("sim_chan", {2'b0, svc_chan}, 4'd1);
    svc_done = 1'b1;
    HLDA = 1'b0;
    DREQ = 4'b0000;
    tick();
    svc_done = 1'b0;
    chk("sim_abort", {3'b0, svc_abort}, 4'd0);
    chk("sim_busy", {3'b0, busy}, 4'd1);
    chk("sim_hrq", {3'b0, HRQ}, 4'd0);
    chk("sim_ptr", {2'b0, dut.r_ptr}, 4'd2);
    tick();
    chk("sim_idle", {3'b0, busy}, 4'd0);

    // Disable blocks new HOLD entry.
    cmd_disable = 1'b1;
    DREQ = 4'b0001;
    tick();
    tick();
    chk("dis_hrq", {3'b0, HRQ}, 4'd0);
    chk("dis_busy", {3'b0, busy}, 4'd0);

    // Disable after grant does not abort; then reset mid-service. Pointer 2 picks channel 3.
    cmd_disable = 1'b0;
    DREQ = 4'b1001;
    tick();
    HLDA = 1'b1;
    tick();
    chk("rs_chan", {2'b0, svc_chan}, 4'd3);
    cmd_disable = 1'b1;
    tick();
    chk("rs_dis_hrq", {3'b0, HRQ}, 4'd1);
    chk("rs_dis_dack", DACK, 4'b0111);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    cmd_disable = 1'b0;
    DREQ = 4'b0000;
    HLDA = 1'b0;
    chk("rs_hrq", {3'b0, HRQ}, 4'd0);
    chk("rs_dack", DACK, 4'b1111);
    chk("rs_busy", {3'b0, busy}, 4'd0);
    chk("rs_ptr", {2'b0, dut.r_ptr}, 4'd0);
    chk("rs_chan0", {2'b0, svc_chan}, 4'd0);

    // Active-high DACK idle level.
    cmd_dack_hi = 1'b1;
    tick();
    chk("ahi_idle", DACK, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/c8237_priority.md
C8237_PRIORITY -- requirements
Module: c8237_priority

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named CLK and RESET.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 DREQ  input  4  raw DMA request pins, one per channel.
REQ-005 HLDA  input  1  CPU hold acknowledge.
REQ-006 cmd_disable  input  1  controller disable (command bit 2).
REQ-007 cmd_rotate  input  1  1 = rotating priority, 0 = fixed priority.
REQ-008 cmd_dreq_lo  input  1  1 = DREQ active-low.
REQ-009 cmd_dack_hi  input  1  1 = DACK active-high.
REQ-010 mask  input  4  per-channel request mask; 1 = masked.
REQ-011 soft_req  input  4  software request bits; unaffected by mask.
REQ-012 svc_done  input  1  one-cycle pulse from the timing FSM: service of the granted channel has finished.
REQ-013 HRQ  output  1  hold request to the CPU.
REQ-014 DACK  output  4  DMA acknowledge; polarity follows cmd_dack_hi.
REQ-015 svc_chan  output  2  granted channel number; held stable while granted.
REQ-016 svc_start  output  1  one-cycle pulse on entry to GRANT.
REQ-017 svc_abort  output  1  one-cycle pulse when HLDA is lost during GRANT.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 Effective request SHALL be eff = ((DREQ ^ {4{cmd_dreq_lo}}) & ~mask) | soft_req, evaluated combinationally each cycle.
REQ-020 States SHALL be: IDLE, HOLD, GRANT, RELEASE.
REQ-021 IDLE: if eff != 0 and cmd_disable = 0, go to HOLD next cycle with HRQ = 1.
REQ-022 HOLD: HRQ = 1; if eff == 0 before HLDA is sampled high, HRQ = 0 and go to IDLE.
REQ-023 HOLD: when HLDA = 1 and eff != 0, latch the winner into svc_chan, assert DACK[svc_chan], pulse svc_start, and go to GRANT.
REQ-024 HOLD to GRANT SHALL take exactly one cycle after HLDA is sampled high, so DACK and svc_start appear on the same edge.
REQ-025 Fixed priority: channel 0 highest, channel 3 lowest.
REQ-026 Rotating priority: a 2-bit pointer names the highest-priority channel; the search order is pointer, pointer+1, ... modulo 4.
REQ-027 Winner selection SHALL occur only in HOLD; eff changes during GRANT do not change svc_chan.
REQ-028 GRANT: HRQ = 1 and DACK[svc_chan] active; on svc_done, go to RELEASE.
REQ-029 On svc_done with cmd_rotate = 1, the pointer SHALL become svc_chan+1 (wrap 3 to 0), making the serviced channel lowest priority.
REQ-030 With cmd_rotate = 0, the pointer is not updated.
REQ-031 GRANT with HLDA = 0 (and no svc_done that cycle): pulse svc_abort, deassert DACK and HRQ, go to IDLE; the pointer is unchanged.
REQ-032 svc_done and an HLDA drop in the same cycle SHALL be treated as svc_done (normal completion).
REQ-033 RELEASE: HRQ = 0 and all DACK inactive; go to IDLE once HLDA = 0.
REQ-034 Minimum RELEASE time SHALL be one cycle, so HRQ is low for at least one cycle between services.
REQ-035 cmd_disable rising SHALL block new HOLD entry but not abort HOLD or GRANT.
REQ-036 Only one DACK bit SHALL ever be active; inactive level = ~cmd_dack_hi on all bits.

Reset
REQ-037 RESET SHALL apply from any state, mid-service included, and take effect on the next edge.
REQ-038 RESET values SHALL be: state IDLE, HRQ = 0, DACK all inactive per current cmd_dack_hi, svc_chan = 0, svc_start = 0, svc_abort = 0, busy = 0, pointer = 0.

Structure
REQ-039 Shared package c8237_pkg SHALL hold: the state enum, CH_N = 4, CH_W = 2.
REQ-040 Sub-module c8237_prio_enc SHALL be the combinational rotating-priority encoder: inputs eff[3:0] and pointer[1:0]; outputs valid and chan[1:0].
REQ-041 Registered outputs SHALL be HRQ, DACK, svc_chan, svc_start and svc_abort; no combinational path from DREQ to HRQ.

Verification
REQ-042 Fixed priority: DREQ = 0110, HLDA high 2 cycles after HRQ -> DACK = 1101 (active-low), svc_chan = 1, svc_start pulse once.
REQ-043 Rotating priority: DREQ = 1111 held, four successive services -> channel order 0, 1, 2, 3, then 0.
REQ-044 Request withdrawn: DREQ pulse removed while in HOLD before HLDA -> HRQ falls, state IDLE, no DACK asserted.
REQ-045 HLDA loss: HLDA drops in GRANT -> svc_abort pulse, DACK = 1111, HRQ = 0 next cycle, pointer unchanged.
REQ-046 Masking and polarity: mask = 0001, DREQ0 active, soft_req = 0100, cmd_dreq_lo = 1 -> channel 2 granted.
REQ-047 Reset mid-service: RESET in GRANT -> next cycle HRQ = 0, DACK inactive, busy = 0, pointer = 0.
